// File: rtl/cpu8_pkg.sv
// Shared opcode, field and state definitions for the 8-bit CPU sequencer.
// CPU8_SINGLE_STEP_EN adds the PAUSE state used for single stepping.
package cpu8_pkg;
    localparam int ALU_SEL_W = 3;

    // Instruction byte layout: [7:5] opcode, [4:3] rd, [2:1] rs, [0] unused
    localparam int OPC_LSB = 5;
    localparam int RD_LSB  = 3;
    localparam int RS_LSB  = 1;

    localparam logic [2:0] OP_ALU0 = 3'd0;
    localparam logic [2:0] OP_ALU1 = 3'd1;
    localparam logic [2:0] OP_ALU2 = 3'd2;
    localparam logic [2:0] OP_ALU3 = 3'd3;
    localparam logic [2:0] OP_ALU4 = 3'd4;
    localparam logic [2:0] OP_ALU5 = 3'd5;
    localparam logic [2:0] OP_LDI  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_IMM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
`ifdef CPU8_SINGLE_STEP_EN
        , ST_PAUSE = 3'd6
`endif
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LDI  = 2'd1,
        CLS_HALT = 2'd2
    } opclass_t;
endpackage

// File: rtl/cpu8_instr_decode.sv
// Combinational instruction-byte decoder: opcode class, register fields, ALU select.
module cpu8_instr_decode
    import cpu8_pkg::*;
#(
    parameter int REG_AW = 2
) (
    input  logic [7:0]           ir,
    output logic [2:0]           opcode,
    output opclass_t             opclass,
    output logic [REG_AW-1:0]    rd,
    output logic [REG_AW-1:0]    rs,
    output logic [ALU_SEL_W-1:0] alu_sel
);
    always_comb begin
        opcode  = ir[OPC_LSB +: 3];
        rd      = ir[RD_LSB +: REG_AW];
        rs      = ir[RS_LSB +: REG_AW];
        opclass = CLS_ALU;
        alu_sel = '0;
        case (opcode)
            OP_LDI:  opclass = CLS_LDI;
            OP_HALT: opclass = CLS_HALT;
            default: alu_sel = opcode;  // only 0..5 ever reach the ALU mux
        endcase
    end
endmodule

// File: rtl/cpu8_control_seq.sv
// Fetch/decode/execute sequencer: pc, instruction fetch handshake, RF/WB controls.
// Define CPU8_SINGLE_STEP_EN to add the step input and PAUSE state after each WB.
module cpu8_control_seq
    import cpu8_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int REG_AW = 2
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef CPU8_SINGLE_STEP_EN
    input  logic                 step,
`endif
    output logic                 imem_req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic                 imem_valid,
    input  logic [7:0]           imem_data,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic [REG_AW-1:0]    rf_raddr_a,
    output logic [REG_AW-1:0]    rf_raddr_b,
    output logic                 rf_we,
    output logic [REG_AW-1:0]    rf_waddr,
    output logic                 wb_sel,
    output logic [7:0]           imm_out,
    output logic [PC_W-1:0]      pc,
    output logic                 halted
);
    state_t                 state, state_nx;
    logic [7:0]             ir;
    logic                   rst_q;
    logic                   ir_ld, imm_ld;
    logic [2:0]             opcode;
    opclass_t               opclass;
    logic [REG_AW-1:0]      rd, rs;
    logic [ALU_SEL_W-1:0]   dec_alu_sel;

    cpu8_instr_decode #(.REG_AW(REG_AW)) u_dec (
        .ir      (ir),
        .opcode  (opcode),
        .opclass (opclass),
        .rd      (rd),
        .rs      (rs),
        .alu_sel (dec_alu_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_FETCH;
            pc      <= '0;
            ir      <= '0;
            imm_out <= '0;
            rst_q   <= 1'b1;
        end else begin
            state <= state_nx;
            rst_q <= 1'b0;
            if (ir_ld) begin
                ir <= imem_data;
                pc <= pc + 1'b1;
            end
            if (imm_ld) begin
                imm_out <= imem_data;
                pc      <= pc + 1'b1;
            end
        end
    end

    // rst_q keeps imem_req low for the cycles reset is being applied, even though
    // the state register already reads FETCH; all outputs stay registered-only.
    always_comb begin
        imem_req   = ((state == ST_FETCH) || (state == ST_IMM)) && !rst_q;
        imem_addr  = pc;
        alu_sel    = '0;
        rf_raddr_a = '0;
        rf_raddr_b = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        wb_sel     = 1'b0;
        halted     = (state == ST_HALT);
        if ((state == ST_EXEC) || (state == ST_WB)) begin
            alu_sel    = dec_alu_sel;
            rf_raddr_a = rd;
            rf_raddr_b = rs;
        end
        if (state == ST_WB) begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            wb_sel   = (opclass == CLS_LDI);
        end
    end

    always_comb begin
        state_nx = state;
        ir_ld    = 1'b0;
        imm_ld   = 1'b0;
        case (state)
            ST_FETCH: if (imem_req && imem_valid) begin
                ir_ld    = 1'b1;
                state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                case (opclass)
                    CLS_HALT: state_nx = ST_HALT;
                    CLS_LDI:  state_nx = ST_IMM;
                    default:  state_nx = ST_EXEC;
                endcase
            end
            ST_EXEC: state_nx = ST_WB;
            ST_IMM: if (imem_req && imem_valid) begin
                imm_ld   = 1'b1;
                state_nx = ST_WB;
            end
`ifdef CPU8_SINGLE_STEP_EN
            ST_WB:    state_nx = ST_PAUSE;
            ST_PAUSE: if (step) state_nx = ST_FETCH;
`else
            ST_WB:    state_nx = ST_FETCH;
`endif
            ST_HALT:  state_nx = ST_HALT;
            default:  state_nx = ST_FETCH;
        endcase
    end
endmodule

// File: tb/tb_cpu8_control_seq.sv
// Directed scoreboard bench for cpu8_control_seq (single-step section when the macro is defined).
module tb_cpu8_control_seq;
    logic       clk = 1'b0;
    logic       reset;
`ifdef CPU8_SINGLE_STEP_EN
    logic       step;
`endif
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [7:0] imem_data;
    logic [2:0] alu_sel;
    logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic       rf_we, wb_sel, halted;
    logic [7:0] imm_out, pc;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] waddr;
        logic       wbs;
        logic [2:0] alu;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] imm;
    } wb_exp_t;
    wb_exp_t sb[$];

    always #5 clk = ~clk;

    cpu8_control_seq dut (
        .clk        (clk),
        .reset      (reset),
`ifdef CPU8_SINGLE_STEP_EN
        .step       (step),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .alu_sel    (alu_sel),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .wb_sel     (wb_sel),
        .imm_out    (imm_out),
        .pc         (pc),
        .halted     (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Answer one fetch: wait for the request, check the address, stall, then pulse valid.
    task automatic serve(input logic [7:0] d, input int waits, input logic [7:0] a);
        int n = 0;
        while (imem_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("imem_req", 32'(imem_req), 32'd1);
        chk("imem_addr", 32'(imem_addr), 32'(a));
        repeat (waits) @(negedge clk);
        chk("req_held", 32'(imem_req), 32'd1);
        imem_valid = 1'b1;
        imem_data  = d;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 8'($urandom);
    endtask

    task automatic push(input logic [7:0] instr, input logic [7:0] imm);
        wb_exp_t e;
        e.waddr = instr[4:3];
        e.ra    = instr[4:3];
        e.rb    = instr[2:1];
        e.wbs   = (instr[7:5] == 3'd6);
        e.alu   = e.wbs ? 3'd0 : instr[7:5];
        e.imm   = imm;
        sb.push_back(e);
    endtask

    // Wait for the rf_we pulse, pop the oldest expectation and compare.
    task automatic wait_wb(output int lat);
        wb_exp_t e;
        int n = 0;
        while (rf_we !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_underflow observed=rf_we expected=none");
        end else begin
            e = sb.pop_front();
            chk("rf_we", 32'(rf_we), 32'd1);
            chk("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
            chk("wb_sel", 32'(wb_sel), 32'(e.wbs));
            chk("alu_sel", 32'(alu_sel), 32'(e.alu));
            if (e.wbs) chk("imm_out", 32'(imm_out), 32'(e.imm));
            else begin
                chk("raddr_a", 32'(rf_raddr_a), 32'(e.ra));
                chk("raddr_b", 32'(rf_raddr_b), 32'(e.rb));
            end
        end
        @(negedge clk);
        chk("we_pulse", 32'(rf_we), 32'd0);
    endtask

    initial begin
        int lat;
        logic [7:0] ins;
        reset      = 1'b1;
        imem_valid = 1'b0;
        imem_data  = 8'h00;
`ifdef CPU8_SINGLE_STEP_EN
        step = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("pre_req", 32'(imem_req), 32'd1);

        // Reset 3 cycles in the middle of a fetch
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_req", 32'(imem_req), 32'd0);
            chk("rst_pc", 32'(pc), 32'd0);
            chk("rst_alu", 32'(alu_sel), 32'd0);
            chk("rst_we", 32'(rf_we) | 32'(wb_sel) << 1 | 32'(halted) << 2, 32'd0);
            chk("rst_imm", 32'(imm_out), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", 32'(imem_addr), 32'd0);

        // ALU op 3, rd=2, rs=1, zero wait
        ins = 8'b011_10_01_0;
        push(ins, 8'h00);
        serve(ins, 0, 8'd0);
        chk("decode_alu", 32'(alu_sel), 32'd0);
        chk("decode_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("exec_alu", 32'(alu_sel), 32'd3);
        chk("exec_ra", 32'(rf_raddr_a), 32'd2);
        chk("exec_rb", 32'(rf_raddr_b), 32'd1);
        chk("exec_we", 32'(rf_we), 32'd0);
        wait_wb(lat);
        chk("alu_lat", 32'(lat), 32'd1);
        chk("next_fetch_req", 32'(imem_req), 32'd1);
        chk("next_fetch_addr", 32'(imem_addr), 32'd1);

        // LDI rd=1 with 3 stall cycles on each byte
        ins = 8'b110_01_00_0;
        push(ins, 8'hA5);
        serve(ins, 3, 8'd1);
        serve(8'hA5, 3, 8'd2);
        wait_wb(lat);
        chk("ldi_lat", 32'(lat), 32'd0);
        chk("ldi_pc", 32'(pc), 32'd3);
        chk("ldi_imm_hold", 32'(imm_out), 32'hA5);

        // Fill addresses 3..254 with ALU ops so the next fetch is at 255
        for (int a = 3; a < 255; a++) begin
            ins = {3'(a % 6), 2'($urandom), 2'($urandom), 1'b0};
            push(ins, 8'h00);
            serve(ins, int'($urandom_range(0, 2)), 8'(a));
            wait_wb(lat);
        end

        // LDI at 255: immediate comes from address 0
        ins = 8'b110_11_00_0;
        push(ins, 8'h3C);
        serve(ins, 0, 8'd255);
        chk("wrap_pc", 32'(pc), 32'd0);
        serve(8'h3C, 1, 8'd0);
        wait_wb(lat);
        chk("wrap_final_pc", 32'(pc), 32'd1);

        // HALT at 1, then spurious valids are ignored
        serve(8'hE0, 0, 8'd1);
        chk("halt_not_yet", 32'(halted), 32'd0);
        @(negedge clk);
        chk("halted", 32'(halted), 32'd1);
        imem_valid = 1'b1;
        repeat (20) begin
            imem_data = 8'($urandom);
            @(negedge clk);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_we", 32'(rf_we), 32'd0);
            chk("halt_pc", 32'(pc), 32'd2);
            chk("halt_stay", 32'(halted), 32'd1);
        end
        imem_valid = 1'b0;

`ifdef CPU8_SINGLE_STEP_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ins = 8'b001_01_10_0;
        push(ins, 8'h00);
        serve(ins, 0, 8'd0);
        wait_wb(lat);
        repeat (10) begin
            @(negedge clk);
            chk("pause_req", 32'(imem_req), 32'd0);
            chk("pause_we", 32'(rf_we), 32'd0);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        ins = 8'b100_11_01_0;
        push(ins, 8'h00);
        serve(ins, 0, 8'd1);
        wait_wb(lat);
        repeat (10) begin
            @(negedge clk);
            chk("pause2_req", 32'(imem_req), 32'd0);
            chk("pause2_we", 32'(rf_we), 32'd0);
        end
        chk("step_pc", 32'(pc), 32'd2);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu8_control_seq.md
Name: cpu8_control_seq

Overview:
- Fetch/decode/execute sequencer for the 8-bit simplified CPU.
- Produces the 3-bit ALU operation select consumed by the 6-input ALU result mux, plus register-file and write-back controls.
- Fetches instruction bytes from instruction memory over a request/valid handshake and keeps the program counter.

Parameters:
- PC_W, 8, program counter / instruction address width.
- REG_AW, 2, register-file address width (4 registers).

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; address valid while high.
- imem_addr  out  PC_W  fetch address (current pc).
- imem_valid  in  1  fetched byte valid this cycle; ignored while imem_req low.
- imem_data  in  8  fetched byte.
- alu_sel  out  3  ALU result-mux select, values 0..5 only.
- rf_raddr_a  out  REG_AW  ALU operand A register (rd).
- rf_raddr_b  out  REG_AW  ALU operand B register (rs).
- rf_we  out  1  register write enable, one-cycle pulse.
- rf_waddr  out  REG_AW  register write address.
- wb_sel  out  1  write-back source: 0 = ALU result, 1 = imm_out.
- imm_out  out  8  latched immediate byte.
- pc  out  PC_W  program counter.
- halted  out  1  high in HALT state.

Behaviour:
- Instruction byte: [7:5] opcode, [4:3] rd, [2:1] rs, [0] unused.
- Opcodes:
  - 0-5: ALU ops; alu_sel = opcode.
  - 6: LDI; next byte is the immediate.
  - 7: HALT.
- States: FETCH, DECODE, EXEC, IMM, WB, HALT. Binary encoding comes from the package.
- Reset (synchronous, clk edge with reset=1):
  - state=FETCH, pc=0, ir=0, imm_out=0.
  - All outputs 0: imem_req, alu_sel, rf_we, wb_sel, halted.
  - Reset mid-fetch abandons the fetch. Instruction memory shares reset, so no stale imem_valid can arrive.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_valid: ir<=imem_data, pc<=pc+1, go DECODE. Otherwise stay; fetch latency is unbounded.
- DECODE:
  - opcode 7 -> HALT.
  - opcode 6 -> IMM.
  - else -> EXEC.
- EXEC:
  - alu_sel=ir opcode, rf_raddr_a=rd, rf_raddr_b=rs.
  - Next state WB. alu_sel and raddrs are held through WB.
- IMM:
  - imem_req=1, imem_addr=pc.
  - On imem_valid: imm_out<=imem_data, pc<=pc+1, go WB.
- WB:
  - rf_we=1, rf_waddr=rd.
  - wb_sel=1 if opcode 6, else 0.
  - Next state FETCH.
- HALT: halted=1, imem_req=0. Stays until reset.
- alu_sel is 0 in every state except EXEC/WB. Values 6/7 are never driven.
- Outputs are decoded only from registered state/ir/pc (Moore). No combinational path from imem_valid/imem_data to any output.
- Minimum latency:
  - ALU instruction: 4 cycles (FETCH with same-cycle valid, DECODE, EXEC, WB).
  - LDI: 4 cycles (FETCH, DECODE, IMM, WB).
- pc wraps 255 -> 0 without a flag. An LDI at address 255 fetches its immediate from address 0.
- rf_we asserts exactly once per non-HALT instruction.

Optional Feature:
- Macro CPU8_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit) and state PAUSE.
  - WB goes to PAUSE instead of FETCH. PAUSE leaves to FETCH on the first cycle step=1.
  - A step already high on entry to PAUSE still counts. A step pulse seen in PAUSE is consumed once.
  - Reset from PAUSE goes to FETCH.
- Undefined: no step port, no PAUSE state; WB -> FETCH directly.

Decomposition:
- Package cpu8_pkg:
  - opcode constants (OP_ALU0..OP_ALU5, OP_LDI=6, OP_HALT=7);
  - state typedef/encoding;
  - instruction field positions;
  - ALU_SEL_W=3.
- One natural sub-module: cpu8_instr_decode. Combinational; maps ir to opcode class, rd, rs and alu_sel. Reusable by a future disassembler monitor.
- The FSM, pc and handshake stay in cpu8_control_seq.

Test Plan:
- Reset check: assert reset 3 cycles mid-FETCH -> pc=0, imem_req=0 during reset, then imem_req=1 with imem_addr=0 on the first cycle after release.
- ALU instruction: memory returns 8'b011_10_01_0 at addr 0 with zero wait -> DECODE, then EXEC with alu_sel=3, raddr_a=2, raddr_b=1, then rf_we=1, rf_waddr=2, wb_sel=0; next fetch at addr 1 on cycle 5.
- LDI with waits: byte 8'b110_01_00_0 at addr 1, imm 8'hA5 at addr 2, each valid after 3 stall cycles -> imm_out=A5, rf_we pulse with rf_waddr=1, wb_sel=1; pc=3 afterwards.
- HALT: byte 8'hE0 -> halted=1 two cycles after valid; imem_req stays 0 and spurious imem_valid is ignored for 20 cycles.
- Wrap: pc=255 executing LDI -> immediate fetched from imem_addr=0, final pc=1.
- Single step (macro on): two ALU instructions, step low -> sequencer parks in PAUSE after the first rf_we; a one-cycle step pulse -> exactly one further instruction.
